ram_arbiter_2p: RTL and testbench



---
 rtl/ram_arbiter_2p.sv | 111 +++++++++++
 tb/tb_ram_arbiter_2p.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_2p.sv
// Two-requester arbiter sharing one synchronous single-port RAM; each access takes 4 cycles.
// Define ARB_FIXED_PRIO_EN to give requester 0 fixed priority on simultaneous requests.
module ram_arbiter_2p #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_direccion,
  output logic [DW-1:0] ram_dato_e,
  output logic          ram_en,
  input  logic [DW-1:0] ram_dato_s
);

  typedef enum logic [1:0] {StIdle, StServe, StResp, StDone} state_e;

  state_e state;
  logic   sel;     // captured winner: 0 or 1
  logic   we_cap;  // captured write flag of the access in flight
  logic   win1;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win1 = req1 & ~req0;
  end
`else
  logic last_grant;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    win1 = req1 & (~req0 | ~last_grant);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      sel           <= 1'b0;
      we_cap        <= 1'b0;
      gnt0          <= 1'b0;
      gnt1          <= 1'b0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      rdata0        <= '0;
      rdata1        <= '0;
      ram_direccion <= '0;
      ram_dato_e    <= '0;
      ram_en        <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_grant    <= 1'b1;
`endif
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        StIdle: begin
          if (req0 | req1) begin
            sel           <= win1;
            we_cap        <= win1 ? we1 : we0;
            ram_direccion <= win1 ? addr1 : addr0;
            ram_dato_e    <= win1 ? wdata1 : wdata0;
            ram_en        <= win1 ? we1 : we0;
            gnt0          <= ~win1;
            gnt1          <= win1;
`ifndef ARB_FIXED_PRIO_EN
            last_grant    <= win1;
`endif
            state         <= StServe;
          end
        end
        StServe: begin
          ram_en <= 1'b0;
          state  <= StResp;
        end
        StResp: begin
          // Registered RAM read data is valid in this cycle.
          if (!we_cap) begin
            if (sel) rdata1 <= ram_dato_s;
            else     rdata0 <= ram_dato_s;
          end
          ack0  <= ~sel;
          ack1  <= sel;
          state <= StDone;
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Self-checking bench for ram_arbiter_2p: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter and RAM.
module tb_ram_arbiter_2p;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, ack0, gnt1, ack1, ram_en;
  logic [DW-1:0] rdata0, rdata1, ram_dato_e, ram_dato_s;
  logic [AW-1:0] ram_direccion;

  logic [DW-1:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  ram_arbiter_2p #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .ack1(ack1), .rdata1(rdata1),
    .ram_direccion(ram_direccion), .ram_dato_e(ram_dato_e),
    .ram_en(ram_en), .ram_dato_s(ram_dato_s)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with registered read.
  always @(posedge clk) begin
    if (ram_en) mem[ram_direccion] <= ram_dato_e;
    ram_dato_s <= mem[ram_direccion];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  // Leaves the bench at a negedge with rst low: the caller's cycle 0.
  task automatic reset_dut();
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      req0 = 1'($urandom); we0 = 1'($urandom); addr0 = 8'($urandom); wdata0 = 8'($urandom);
      req1 = 1'($urandom); we1 = 1'($urandom); addr1 = 8'($urandom); wdata1 = 8'($urandom);
      tick();
      n_tests++;
      if ({gnt0, gnt1, ack0, ack1, ram_en, ram_direccion, ram_dato_e, rdata0, rdata1} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got gnt=%b%b ack=%b%b en=%b addr=%h wd=%h rd=%h/%h, all 0 required",
                 i, gnt0, gnt1, ack0, ack1, ram_en, ram_direccion, ram_dato_e, rdata0, rdata1);
      end
    end
    idle_inputs();
  endtask

  task automatic test_single_read();
    mem[3] = 8'h33;
    reset_dut();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd3; wdata0 = 8'($urandom);
    tick();  // cycle 1
    n_tests++;
    if ({gnt0, gnt1, ram_en, ram_direccion} !== {1'b1, 1'b0, 1'b0, 8'd3}) begin
      n_fail++;
      $display("FAIL read_grant: got gnt0=%b gnt1=%b en=%b addr=%h, required 1 0 0 03",
               gnt0, gnt1, ram_en, ram_direccion);
    end
    req0 = 1'b0;
    tick();  // cycle 2
    n_tests++;
    if ({gnt0, gnt1, ack0, ack1} !== 4'b0000) begin
      n_fail++;
      $display("FAIL read_resp_quiet: got gnt=%b%b ack=%b%b, required 0000", gnt0, gnt1, ack0, ack1);
    end
    tick();  // cycle 3
    n_tests++;
    if ({ack0, ack1, gnt1, rdata0} !== {1'b1, 1'b0, 1'b0, 8'h33}) begin
      n_fail++;
      $display("FAIL read_ack: got ack0=%b ack1=%b gnt1=%b rdata0=%h, required 1 0 0 33",
               ack0, ack1, gnt1, rdata0);
    end
    tick();  // cycle 4
    n_tests++;
    if ({ack0, ack1} !== 2'b00) begin
      n_fail++;
      $display("FAIL read_ack_pulse: got ack0=%b ack1=%b, required 0 0", ack0, ack1);
    end
  endtask

  task automatic test_write_read();
    int en_cnt = 0;
    reset_dut();
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'd0; wdata1 = 8'hff;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (ram_en === 1'b1) en_cnt++;
      if (c == 1) begin
        n_tests++;
        if ({gnt1, gnt0, ram_en, ram_direccion, ram_dato_e} !== {1'b1, 1'b0, 1'b1, 8'd0, 8'hff}) begin
          n_fail++;
          $display("FAIL write_present: got gnt1=%b gnt0=%b en=%b addr=%h wd=%h, required 1 0 1 00 ff",
                   gnt1, gnt0, ram_en, ram_direccion, ram_dato_e);
        end
        req1 = 1'b0;
      end
    end
    n_tests++;
    if (en_cnt != 1) begin
      n_fail++;
      $display("FAIL write_en_cycles: got %0d cycles of ram_en, required 1", en_cnt);
    end
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd0;  // cycle 4, back in idle
    tick();
    req1 = 1'b0;
    tick();
    tick();  // cycle 7
    n_tests++;
    if ({ack1, ack0, rdata1} !== {1'b1, 1'b0, 8'hff}) begin
      n_fail++;
      $display("FAIL write_readback: got ack1=%b ack0=%b rdata1=%h, required 1 0 ff", ack1, ack0, rdata1);
    end
  endtask

  task automatic test_tie();
    int g0 = -1, g1 = -1;
    logic [DW-1:0] r0 = '0, r1 = '0;
    reset_dut();
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd5; wdata0 = 8'd123;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'd9; wdata1 = 8'd77;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (gnt0 === 1'b1 && g0 < 0) begin g0 = c; req0 = 1'b0; end
      if (gnt1 === 1'b1 && g1 < 0) begin g1 = c; req1 = 1'b0; end
    end
    n_tests++;
    if (g0 != 1 || g1 != 5) begin
      n_fail++;
      $display("FAIL tie_write_order: got gnt0@%0d gnt1@%0d, required gnt0@1 gnt1@5", g0, g1);
    end
    g0 = -1; g1 = -1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd9;
    for (int c = 9; c <= 16; c++) begin
      tick();
      if (gnt0 === 1'b1 && g0 < 0) begin g0 = c; req0 = 1'b0; end
      if (gnt1 === 1'b1 && g1 < 0) begin g1 = c; req1 = 1'b0; end
      if (ack0 === 1'b1) r0 = rdata0;
      if (ack1 === 1'b1) r1 = rdata1;
    end
    n_tests++;
    if (g0 != 9 || g1 != 13) begin
      n_fail++;
      $display("FAIL tie_read_order: got gnt0@%0d gnt1@%0d, required gnt0@9 gnt1@13", g0, g1);
    end
    n_tests++;
    if (r0 !== 8'd123 || r1 !== 8'd77) begin
      n_fail++;
      $display("FAIL tie_readback: got rdata0=%0d rdata1=%0d, required 123 77", r0, r1);
    end
  endtask

  task automatic test_reset_mid();
    int g1 = -1, a1 = -1, a0 = 0;
    logic [DW-1:0] r1 = '0;
    reset_dut();
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h42; wdata0 = 8'ha5;
    tick();  // cycle 1: serve
    n_tests++;
    if ({gnt0, ram_en} !== 2'b11) begin
      n_fail++;
      $display("FAIL midreset_serve: got gnt0=%b en=%b, required 1 1", gnt0, ram_en);
    end
    req0 = 1'b0;
    rst  = 1'b1;
    tick();  // cycle 2
    n_tests++;
    if ({gnt0, gnt1, ack0, ack1, ram_en, ram_direccion, ram_dato_e} !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: got gnt=%b%b ack=%b%b en=%b addr=%h wd=%h, all 0 required",
               gnt0, gnt1, ack0, ack1, ram_en, ram_direccion, ram_dato_e);
    end
    rst  = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h42;
    for (int c = 3; c <= 7; c++) begin
      tick();
      if (gnt1 === 1'b1 && g1 < 0) begin g1 = c; req1 = 1'b0; end
      if (ack1 === 1'b1) begin a1 = c; r1 = rdata1; end
      if (ack0 === 1'b1) a0++;
    end
    n_tests++;
    if (g1 != 3 || a1 != 5 || a0 != 0 || r1 !== 8'ha5) begin
      n_fail++;
      $display("FAIL midreset_after: got gnt1@%0d ack1@%0d ack0 count %0d rdata1=%h, required 3 5 0 a5",
               g1, a1, a0, r1);
    end
  endtask

  task automatic test_alternate();
    logic [2:0] got = '0;
    logic [2:0] exp;
    int         n = 0;
`ifdef ARB_FIXED_PRIO_EN
    exp = 3'b000;
`else
    exp = 3'b010;
`endif
    reset_dut();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'($urandom);
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'($urandom);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
        got = {got[1:0], gnt1};
        n++;
      end
    end
    idle_inputs();
    n_tests++;
    if (n != 3 || got !== exp) begin
      n_fail++;
      $display("FAIL grant_sequence: got %0d grants pattern %b, required 3 grants pattern %b", n, got, exp);
    end
  endtask

  // Transaction-level model: an access accepted at cycle c grants at c+1, acks at c+3,
  // and the arbiter looks at requests again at c+4.
  task automatic test_random();
    logic [DW-1:0] mem_m [256];
    logic [DW-1:0] rd_m [2];
    logic [DW-1:0] fly_rd = '0;
    int  free_at = 0, gnt_at = -1, ack_at = -1;
    bit  last = 1'b1, who = 1'b0, fly_we = 1'b0;
    logic [6:0] act, exp;
    rst = 1'b1;
    idle_inputs();
    tick();
    for (int a = 0; a < 256; a++) begin
      mem[a]   = 8'($urandom);
      mem_m[a] = mem[a];
    end
    rd_m[0] = '0;
    rd_m[1] = '0;
    reset_dut();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (ack_at == cyc && !fly_we) rd_m[who] = fly_rd;
      exp = {gnt_at == cyc && !who, gnt_at == cyc && who,
             ack_at == cyc && !who, ack_at == cyc && who,
             gnt_at == cyc && fly_we, 2'b00};
      act = {gnt0, gnt1, ack0, ack1, ram_en, 2'b00};
      n_tests++;
      if (act !== exp || rdata0 !== rd_m[0] || rdata1 !== rd_m[1]) begin
        n_fail++;
        $display("FAIL random cycle %0d: got g/a/en=%b rd=%h/%h, required %b rd=%h/%h",
                 cyc, act[6:2], rdata0, rdata1, exp[6:2], rd_m[0], rd_m[1]);
      end
      if (!req0 || gnt0 === 1'b1) begin
        req0 = ($urandom_range(0, 2) == 0);
        we0 = 1'($urandom); addr0 = 8'($urandom_range(0, 15)); wdata0 = 8'($urandom);
      end
      if (!req1 || gnt1 === 1'b1) begin
        req1 = ($urandom_range(0, 2) == 0);
        we1 = 1'($urandom); addr1 = 8'($urandom_range(0, 15)); wdata1 = 8'($urandom);
      end
      if (cyc >= free_at && (req0 || req1)) begin
        if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
          who = 1'b0;
`else
          who = (last == 1'b0);
`endif
        end else begin
          who = req1;
        end
        last    = who;
        gnt_at  = cyc + 1;
        ack_at  = cyc + 3;
        free_at = cyc + 4;
        fly_we  = who ? we1 : we0;
        if (fly_we) mem_m[who ? addr1 : addr0] = who ? wdata1 : wdata0;
        else        fly_rd = mem_m[who ? addr1 : addr0];
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_tie();
    test_reset_mid();
    test_alternate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
